fighter_core: RTL and testbench

Parametrised per-player combat state machine for the two-player fighting game. One instance per player; the top level cross-wires each instance's position and action to the other. Generalises the fixed three-position, 2-bit-health player FSM to an N-position arena with configurable health, damage and reach. Adds attack cooldown, defensive actions, kick-clash knockback and a knockout state.

---
 rtl/fighter_pkg.sv | 18 +
 rtl/fighter_if.sv | 25 ++
 rtl/cooldown_timer.sv | 20 ++
 rtl/fighter_core.sv | 98 +++++++++
 tb/tb_fighter_core.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/fighter_pkg.sv
// fighter_pkg: shared action codes, combat states and saturating subtract
package fighter_pkg;
    localparam logic [2:0] A_KICK   = 3'b000;
    localparam logic [2:0] A_PUNCH  = 3'b001;
    localparam logic [2:0] A_AWAIT  = 3'b010;
    localparam logic [2:0] A_JUMP   = 3'b011;
    localparam logic [2:0] A_LEFT1  = 3'b100;
    localparam logic [2:0] A_LEFT2  = 3'b101;
    localparam logic [2:0] A_RIGHT1 = 3'b110;
    localparam logic [2:0] A_RIGHT2 = 3'b111;

    typedef enum logic [1:0] {ALIVE, RECOVER, KO} state_t;

    // Width-generic: callers widen operands to 32 bits and truncate the result.
    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        return a > b ? a - b : '0;
    endfunction
endpackage

// File: rtl/fighter_if.sv
// fighter_if: per-player action inputs and combat status outputs
interface fighter_if #(
    parameter int POS_W    = 3,
    parameter int HEALTH_W = 4
);
    logic                act_valid;
    logic [2:0]          act_self;
    logic [2:0]          act_opp;
    logic                opp_busy;
    logic [POS_W-1:0]    opp_pos;
    logic [POS_W-1:0]    pos;
    logic [HEALTH_W-1:0] health;
    logic                ko;
    logic                hit_taken;
    logic                busy;

    modport master (
        output act_valid, act_self, act_opp, opp_busy, opp_pos,
        input  pos, health, ko, hit_taken, busy
    );
    modport slave (
        input  act_valid, act_self, act_opp, opp_busy, opp_pos,
        output pos, health, ko, hit_taken, busy
    );
endinterface

// File: rtl/cooldown_timer.sv
// cooldown_timer: loadable down-counter that parks at zero
module cooldown_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic [W-1:0] count,
    output logic         zero
);
    assign zero = count == '0;

    // load wins; otherwise count down until zero
    always_ff @(posedge clk) begin
        if (rst) count <= '0;
        else if (load) count <= value;
        else if (!zero) count <= count - 1'b1;
    end
endmodule

// File: rtl/fighter_core.sv
// fighter_core: per-player combat FSM with movement, damage, cooldown and knockout
module fighter_core
    import fighter_pkg::*;
#(
    parameter int NUM_POS     = 8,
    parameter int HEALTH_W    = 4,
    parameter int HEALTH_INIT = 15,
    parameter int START_POS   = 0,
    parameter int MIRROR      = 0,
    parameter int KICK_DMG    = 1,
    parameter int PUNCH_DMG   = 2,
    parameter int KICK_REACH  = 2,
    parameter int COOLDOWN    = 2
) (
    input logic     clk,
    input logic     rst,
    fighter_if.slave io
);
    localparam int POS_W = $clog2(NUM_POS);
    localparam int CW    = COOLDOWN > 0 ? $clog2(COOLDOWN + 1) : 1;

    state_t              state;
    logic [POS_W-1:0]    pos_q, pos_next;
    logic [HEALTH_W-1:0] health_q, h_next;
    logic                ko_q, hit_q, busy_q;
    logic [2:0]          eff;
    logic                clash, kick_hit, punch_hit, attack, load, rec_done, cd_zero;
    logic [CW-1:0]       cd_count;
    int                  p, o, d, dmg, step, tgt, clamped, fenced;

    // incoming damage first, then own action, all against pre-update positions
    always_comb begin
        p         = int'(pos_q);
        o         = int'(io.opp_pos);
        d         = p > o ? p - o : o - p;
        eff       = (state == RECOVER && io.act_self[2:1] == 2'b00) ? A_AWAIT : io.act_self;
        clash     = eff == A_KICK && io.act_opp == A_KICK && d == 1 && !io.opp_busy;
        kick_hit  = io.act_opp == A_KICK && !io.opp_busy && d >= 1 && d <= KICK_REACH && eff != A_JUMP && !clash;
        punch_hit = io.act_opp == A_PUNCH && !io.opp_busy && d == 1 && eff != A_AWAIT;
        dmg       = kick_hit ? KICK_DMG : punch_hit ? PUNCH_DMG : 0;
        h_next    = HEALTH_W'(sat_sub(32'(health_q), 32'(dmg)));
        step      = !eff[2] ? 0 : eff[0] ? 2 : 1;
        tgt       = (eff[1] ^ (MIRROR != 0)) ? p + step : p - step;
        clamped   = tgt < 0 ? 0 : tgt > NUM_POS - 1 ? NUM_POS - 1 : tgt;
        fenced    = o == p ? p : (o > p && clamped >= o) ? o - 1 : (o < p && clamped <= o) ? o + 1 : clamped;
        pos_next  = POS_W'(clash ? (o > p ? (p > 0 ? p - 1 : 0) : (p < NUM_POS - 1 ? p + 1 : p)) : fenced);
        attack    = eff[2:1] == 2'b00 && COOLDOWN > 0;
        load      = io.act_valid && state != KO && h_next != '0 && attack;
        rec_done  = cd_zero || cd_count == CW'(1);
    end

    cooldown_timer #(.W(CW)) u_cd (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .value (CW'(COOLDOWN)),
        .count (cd_count),
        .zero  (cd_zero)
    );

    // combat state and registered outputs; later assignments override the cooldown exit
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ALIVE;
            pos_q    <= POS_W'(START_POS);
            health_q <= HEALTH_W'(HEALTH_INIT);
            ko_q     <= 1'b0;
            hit_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else if (state != KO) begin
            hit_q <= io.act_valid && dmg != 0;
            if (state == RECOVER && rec_done) begin
                state  <= ALIVE;
                busy_q <= 1'b0;
            end
            if (io.act_valid) begin
                health_q <= h_next;
                if (h_next == '0) begin
                    state  <= KO;
                    ko_q   <= 1'b1;
                    busy_q <= 1'b0;
                end else begin
                    pos_q <= pos_next;
                    if (attack) begin
                        state  <= RECOVER;
                        busy_q <= 1'b1;
                    end
                end
            end
        end else hit_q <= 1'b0;
    end

    assign io.pos       = pos_q;
    assign io.health    = health_q;
    assign io.ko        = ko_q;
    assign io.hit_taken = hit_q;
    assign io.busy      = busy_q;
endmodule

// File: tb/tb_fighter_core.sv
// tb_fighter_core: directed scenarios plus random play checked against a behavioural model
module tb_fighter_core;
    localparam bit [2:0] KICK = 0, PUNCH = 1, AWAIT = 2, JUMP = 3, L1 = 4, L2 = 5, R1 = 6, R2 = 7;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    bit   chk_en = 0;

    int m_pos, m_hp, m_cool;
    bit m_ko, m_hit;
    int a, ao, op, d, dmg, nx;
    bit rec, clash, ob;

    fighter_if #(.POS_W(3), .HEALTH_W(4)) bus ();

    fighter_core dut (
        .clk (clk),
        .rst (rst),
        .io  (bus.slave)
    );

    always #5 clk = ~clk;

    // reference model: rules applied one step at a time to plain integers
    always @(posedge clk) begin
        if (rst) begin
            m_pos = 0; m_hp = 15; m_ko = 0; m_hit = 0; m_cool = 0;
        end else if (m_ko) begin
            m_hit = 0;
        end else begin
            rec = m_cool > 0;
            if (rec) m_cool--;
            m_hit = 0;
            if (bus.act_valid) begin
                a  = int'(bus.act_self);
                ao = int'(bus.act_opp);
                op = int'(bus.opp_pos);
                ob = bus.opp_busy;
                if (rec && a <= 1) a = 2;
                d = m_pos > op ? m_pos - op : op - m_pos;
                clash = a == 0 && ao == 0 && d == 1 && !ob;
                dmg = 0;
                if (ao == 0 && !ob && d >= 1 && d <= 2 && a != 3 && !clash) dmg = 1;
                if (ao == 1 && !ob && d == 1 && a != 2) dmg = 2;
                m_hp  = m_hp > dmg ? m_hp - dmg : 0;
                m_hit = dmg > 0;
                if (m_hp == 0) begin
                    m_ko = 1; m_cool = 0;
                end else begin
                    if (clash) m_pos = op > m_pos ? (m_pos > 0 ? m_pos - 1 : 0) : (m_pos < 7 ? m_pos + 1 : 7);
                    else if (a >= 4)
                        for (int i = 0; i < (a % 2) + 1; i++) begin
                            nx = a >= 6 ? m_pos + 1 : m_pos - 1;
                            if (nx >= 0 && nx <= 7 && nx != op) m_pos = nx;
                        end
                    if (a <= 1) m_cool = 2;
                end
            end
        end
    end

    // every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (bus.pos !== 3'(m_pos) || bus.health !== 4'(m_hp) || bus.ko !== m_ko ||
                bus.hit_taken !== m_hit || bus.busy !== (m_cool > 0)) begin
                errors++;
                $display("FAIL model t=%0t: got pos=%0d hp=%0d ko=%0d hit=%0d busy=%0d, expected pos=%0d hp=%0d ko=%0d hit=%0d busy=%0d",
                         $time, bus.pos, bus.health, bus.ko, bus.hit_taken, bus.busy,
                         m_pos, m_hp, m_ko, m_hit, m_cool > 0);
            end
        end
    end

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    task automatic go(input bit v, input bit [2:0] s, input bit [2:0] o, input bit b, input int p);
        @(negedge clk);
        bus.act_valid = v; bus.act_self = s; bus.act_opp = o; bus.opp_busy = b; bus.opp_pos = 3'(p);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        bus.act_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        chk("rst_pos", bus.pos, 0);
        chk("rst_health", bus.health, 15);
        chk("rst_ko", bus.ko, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_hit", bus.hit_taken, 0);
        chk_en = 1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.act_valid = 0; bus.act_self = AWAIT; bus.act_opp = AWAIT; bus.opp_busy = 0; bus.opp_pos = 3'd7;
        do_reset(2);
        for (int i = 1; i <= 3; i++) begin
            go(1, R1, AWAIT, 0, 7);
            chk("right1", bus.pos, i);
        end
        go(1, R2, AWAIT, 0, 7); chk("right2_free", bus.pos, 5);
        go(1, R2, AWAIT, 0, 7); chk("right2_adjacent", bus.pos, 6);
        repeat (3) go(1, L2, AWAIT, 0, 7);
        chk("left2_to_0", bus.pos, 0);
        go(1, L2, AWAIT, 0, 7); chk("left2_clamp", bus.pos, 0);
        go(1, R2, AWAIT, 0, 7);
        go(1, R1, AWAIT, 0, 7); chk("setup_pos3", bus.pos, 3);
        go(1, JUMP, PUNCH, 0, 4); chk("punch_hp", bus.health, 13); chk("punch_hit", bus.hit_taken, 1);
        go(0, AWAIT, PUNCH, 0, 4); chk("hit_pulse_end", bus.hit_taken, 0); chk("idle_hp", bus.health, 13);
        go(1, AWAIT, KICK, 0, 5); chk("kick_reach2", bus.health, 12);
        go(1, JUMP, KICK, 0, 4); chk("jump_dodge", bus.health, 12); chk("jump_no_hit", bus.hit_taken, 0);
        go(1, AWAIT, PUNCH, 0, 4); chk("await_block", bus.health, 12);
        go(1, JUMP, PUNCH, 1, 4); chk("opp_busy_void", bus.health, 12);
        go(1, PUNCH, AWAIT, 0, 7); chk("cd_t", bus.busy, 1);
        go(1, KICK, AWAIT, 0, 7); chk("cd_t1", bus.busy, 1);
        go(1, AWAIT, AWAIT, 0, 7); chk("cd_t2", bus.busy, 0);
        go(1, KICK, AWAIT, 0, 7); chk("cd_reenter", bus.busy, 1);
        go(0, AWAIT, AWAIT, 0, 7);
        go(0, AWAIT, AWAIT, 0, 7); chk("cd_done", bus.busy, 0);
        go(1, KICK, KICK, 0, 4);
        chk("clash_pos", bus.pos, 2); chk("clash_hp", bus.health, 12); chk("clash_busy", bus.busy, 1);
        go(0, AWAIT, AWAIT, 0, 3);
        go(0, AWAIT, AWAIT, 0, 3);
        repeat (5) go(1, JUMP, PUNCH, 0, 3);
        go(1, AWAIT, KICK, 0, 3); chk("hp_one", bus.health, 1);
        go(1, JUMP, PUNCH, 0, 3);
        chk("ko_hp", bus.health, 0); chk("ko_flag", bus.ko, 1); chk("ko_busy", bus.busy, 0);
        go(1, R1, AWAIT, 0, 7); chk("ko_frozen", bus.pos, 2); chk("ko_stays", bus.ko, 1);
        do_reset(1);
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst = ($urandom % 80) == 0;
            bus.act_valid = ($urandom % 4) != 0;
            bus.act_self  = 3'($urandom);
            bus.act_opp   = 3'($urandom);
            bus.opp_busy  = ($urandom % 4) == 0;
            op = int'($urandom_range(7));
            while (op == m_pos) op = int'($urandom_range(7));
            bus.opp_pos = 3'(op);
            @(posedge clk);
            #1;
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
